// File: rtl/calc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : calc_seq
//  Purpose  : Sequential four-function calculator (add, |A-B|, multiply,
//             divide) with start/busy/done handshake. Multiply and divide
//             iterate one bit per cycle; the binary result is then converted
//             to packed BCD by a sequential double-dabble engine.
//  Ports    : clk, rst        - clock (rising edge), async active-high reset
//             start, A, B, K  - request and operands/opcode, sampled in IDLE
//                               (K: 00 add, 01 sub, 10 mul, 11 div)
//             busy, done      - state != IDLE; one-cycle completion pulse
//             result, sign    - binary magnitude; 1 when sub and A < B
//             err, bcd        - divide-by-zero flag; packed BCD of result
//             rem             - divide remainder (only with CALC_REMAINDER_EN)
//  Options  : `define CALC_REMAINDER_EN adds the rem output port.
//  Revision : 1.0 - initial release
// ============================================================================
module calc_seq #(
  parameter int W    = 3,
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      A,
  input  logic [W-1:0]      B,
  input  logic [1:0]        K,
  output logic              busy,
  output logic              done,
  output logic [2*W-1:0]    result,
  output logic              sign,
  output logic              err,
  output logic [4*NDIG-1:0] bcd
`ifdef CALC_REMAINDER_EN
  ,
  output logic [W-1:0]      rem
`endif
);

  localparam int c_CW = $clog2(2*W+1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_CONV = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MUL = 2'b10;
  localparam logic [1:0] c_OP_DIV = 2'b11;

  localparam logic [c_CW-1:0] c_ITER_LAST = c_CW'(W-1);
  localparam logic [c_CW-1:0] c_CONV_LAST = c_CW'(2*W-1);

  logic [1:0]        r_state, w_next;
  logic [W-1:0]      r_a, r_b;
  logic [1:0]        r_k;
  logic [c_CW-1:0]   r_cnt;
  logic [2*W-1:0]    r_acc, r_mcand;
  logic [W-1:0]      r_mplier;
  logic [W-1:0]      r_rem, r_quo;
  logic [2*W-1:0]    r_res, r_sh;
  logic [4*NDIG-1:0] r_bcdw;
  logic [2*W-1:0]    r_result;
  logic [4*NDIG-1:0] r_bcd;
  logic              r_sign, r_err;

  logic              w_div0, w_exec_last, w_conv_last;
  logic [2*W-1:0]    w_acc_next, w_exec_res;
  logic [W:0]        w_shift, w_trial;
  logic              w_qbit;
  logic [W-1:0]      w_rem_next, w_quo_next, w_diff;
  logic [4*NDIG-2:0] w_adj;
  logic [4*NDIG-1:0] w_dd_next;

  assign w_div0      = (K == c_OP_DIV) && (B == '0);
  // Only multiply/divide (K[1]=1) iterate; add/sub finish in one EXEC cycle.
  assign w_exec_last = r_k[1] ? (r_cnt == c_ITER_LAST) : 1'b1;
  assign w_conv_last = (r_cnt == c_CONV_LAST);

  // Shift-add multiplier step, LSB of the multiplier first.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Restoring divider step: bring in the next dividend bit, trial-subtract,
  // keep the difference only when it did not go negative.
  assign w_shift    = {r_rem, r_quo[W-1]};
  assign w_trial    = w_shift - {1'b0, r_b};
  assign w_qbit     = ~w_trial[W];
  assign w_rem_next = w_qbit ? w_trial[W-1:0] : w_shift[W-1:0];
  assign w_quo_next = (r_quo << 1) | W'(w_qbit);

  assign w_diff = (r_a >= r_b) ? (r_a - r_b) : (r_b - r_a);

  always_comb begin
    w_exec_res = '0;
    case (r_k)
      c_OP_ADD: w_exec_res = {{W{1'b0}}, r_a} + {{W{1'b0}}, r_b};
      c_OP_SUB: w_exec_res = {{W{1'b0}}, w_diff};
      c_OP_MUL: w_exec_res = w_acc_next;
      default:  w_exec_res = {{W{1'b0}}, w_quo_next};
    endcase
  end

  // Double-dabble: add 3 to each digit >= 5, then shift left one bit. The top
  // bit of the most significant digit is shifted out, so only its low three
  // bits are carried.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    logic [3:0] w_d;
    assign w_d = r_bcdw[4*i +: 4];
    if (i == NDIG-1) begin : g_top
      assign w_adj[4*i +: 3] = (w_d >= 4'd5) ? (w_d[2:0] + 3'd3) : w_d[2:0];
    end else begin : g_low
      assign w_adj[4*i +: 4] = (w_d >= 4'd5) ? (w_d + 4'd3) : w_d;
    end
  end
  assign w_dd_next = {w_adj, r_sh[2*W-1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (start)       w_next = w_div0 ? c_DONE : c_EXEC;
      c_EXEC: if (w_exec_last) w_next = c_CONV;
      c_CONV: if (w_conv_last) w_next = c_DONE;
      default:                 w_next = c_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    busy = (r_state != c_IDLE);
    done = (r_state == c_DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_res    <= '0;
      r_sh     <= '0;
      r_bcdw   <= '0;
      r_result <= '0;
      r_bcd    <= '0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_k      <= K;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, A};
            r_mplier <= B;
            r_rem    <= '0;
            r_quo    <= A;
            if (w_div0) begin
              r_result <= '0;
              r_bcd    <= {{(4*NDIG-4){1'b0}}, 4'hE};
              r_sign   <= 1'b0;
              r_err    <= 1'b1;
            end
          end
        end
        c_EXEC: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_next;
          r_quo    <= w_quo_next;
          if (w_exec_last) begin
            r_cnt  <= '0;
            r_res  <= w_exec_res;
            r_sh   <= w_exec_res;
            r_bcdw <= '0;
          end
        end
        c_CONV: begin
          r_cnt  <= r_cnt + 1'b1;
          r_sh   <= r_sh << 1;
          r_bcdw <= w_dd_next;
          if (w_conv_last) begin
            r_result <= r_res;
            r_bcd    <= w_dd_next;
            r_sign   <= (r_k == c_OP_SUB) && (r_a < r_b);
            r_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALC_REMAINDER_EN
  logic [W-1:0] r_rem_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem_out <= '0;
    end else if (r_state == c_IDLE && start && w_div0) begin
      r_rem_out <= '0;
    end else if (r_state == c_CONV && w_conv_last) begin
      r_rem_out <= (r_k == c_OP_DIV) ? r_rem : '0;
    end
  end

  assign rem = r_rem_out;
`endif

  assign result = r_result;
  assign bcd    = r_bcd;
  assign sign   = r_sign;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_seq
//  Purpose  : Self-checking bench for calc_seq (W=3, NDIG=2): table of
//             directed operations plus hand-written handshake/reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calc_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] A = '0, B = '0;
  logic [1:0] K = '0;
  logic       busy, done, sign, err;
  logic [5:0] result;
  logic [7:0] bcd;
`ifdef CALC_REMAINDER_EN
  logic [2:0] rem;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  calc_seq #(.W(3), .NDIG(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .K      (K),
    .busy   (busy),
    .done   (done),
    .result (result),
    .sign   (sign),
    .err    (err),
    .bcd    (bcd)
`ifdef CALC_REMAINDER_EN
    ,
    .rem    (rem)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] k;
    int         res;
    int         bcd;
    int         sgn;
    int         err;
    int         rem;
    int         lat;  // edges from the accepting edge to DONE entry
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic run_op(input logic [2:0] a, input logic [2:0] b,
                        input logic [1:0] k, output int lat);
    @(negedge clk);
    A = a; B = b; K = k; start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int lat;

    //           a     b     k      res bcd    s  e  rem lat
    vt[0]  = '{3'd7, 3'd6, 2'b00, 13, 'h13, 0, 0, 0, 7};
    vt[1]  = '{3'd5, 3'd7, 2'b01,  2, 'h02, 1, 0, 0, 7};
    vt[2]  = '{3'd4, 3'd4, 2'b01,  0, 'h00, 0, 0, 0, 7};
    vt[3]  = '{3'd7, 3'd7, 2'b10, 49, 'h49, 0, 0, 0, 9};
    vt[4]  = '{3'd7, 3'd2, 2'b11,  3, 'h03, 0, 0, 1, 9};
    // Divide by zero goes straight to DONE on the accepting edge.
    vt[5]  = '{3'd6, 3'd0, 2'b11,  0, 'h0E, 0, 1, 0, 0};
    vt[6]  = '{3'd0, 3'd0, 2'b00,  0, 'h00, 0, 0, 0, 7};
    vt[7]  = '{3'd7, 3'd0, 2'b01,  7, 'h07, 0, 0, 0, 7};
    vt[8]  = '{3'd5, 3'd6, 2'b10, 30, 'h30, 0, 0, 0, 9};
    vt[9]  = '{3'd6, 3'd7, 2'b11,  0, 'h00, 0, 0, 6, 9};
    vt[10] = '{3'd7, 3'd1, 2'b11,  7, 'h07, 0, 0, 0, 9};
    vt[11] = '{3'd3, 3'd6, 2'b01,  3, 'h03, 1, 0, 0, 7};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",   int'(busy),   0);
    chk("rst_done",   int'(done),   0);
    chk("rst_result", int'(result), 0);
    chk("rst_bcd",    int'(bcd),    0);
    chk("rst_sign",   int'(sign),   0);
    chk("rst_err",    int'(err),    0);

    // Table-driven operations
    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].k, lat);
      chk($sformatf("v%0d_latency", i), lat,          vt[i].lat);
      chk($sformatf("v%0d_result", i),  int'(result), vt[i].res);
      chk($sformatf("v%0d_bcd", i),     int'(bcd),    vt[i].bcd);
      chk($sformatf("v%0d_sign", i),    int'(sign),   vt[i].sgn);
      chk($sformatf("v%0d_err", i),     int'(err),    vt[i].err);
`ifdef CALC_REMAINDER_EN
      chk($sformatf("v%0d_rem", i),     int'(rem),    vt[i].rem);
`endif
    end

    // start held during the DONE cycle must not be accepted
    run_op(3'd2, 3'd3, 2'b00, lat);
    chk("seq_add_result", int'(result), 5);
    A = 3'd1; B = 3'd1; K = 2'b00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("done_start_ignored_busy", int'(busy), 0);
    start = 1'b0;

    // start pulsed while a multiply is busy is ignored
    @(negedge clk);
    A = 3'd7; B = 3'd7; K = 2'b10; start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    lat++;
    @(negedge clk);
    A = 3'd1; B = 3'd1; K = 2'b00; start = 1'b1;
    chk("busy_mid_mul", int'(busy), 1);
    chk("held_result", int'(result), 5);
    @(posedge clk);
    lat++;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_latency", lat, 9);
    chk("ign_result", int'(result), 49);
    chk("ign_bcd", int'(bcd), 'h49);

    // Asynchronous reset four cycles into a multiply
    @(negedge clk);
    A = 3'd7; B = 3'd5; K = 2'b10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   int'(busy),   0);
    chk("arst_done",   int'(done),   0);
    chk("arst_result", int'(result), 0);
    chk("arst_bcd",    int'(bcd),    0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd3, 3'd3, 2'b10, lat);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_result", int'(result), 9);
    chk("post_rst_bcd", int'(bcd), 'h09);
    chk("post_rst_err", int'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
